// File: rtl/fdc_multich.sv
// fdc_multich: multi-channel frequency-to-digital converter.
// Counts rising edges on N_CH asynchronous VCO inputs over a gate window of
// gate_len clk_ref periods and streams the per-channel counts out over a
// valid/ready interface. Supports single-shot and continuous operation.
module fdc_multich #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ref,
  input  logic [N_CH-1:0]   vco,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              mode,
  input  logic              start,
  output logic              busy,
  output logic [CNT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);

  // Synchroniser chains and edge-detect history
  logic [SYNC_STAGES-1:0]            ref_sync_q;
  logic                              ref_prev_q;
  logic [N_CH-1:0][SYNC_STAGES-1:0]  vco_sync_q;
  logic [N_CH-1:0]                   vco_prev_q;
  logic                              ref_p;
  logic [N_CH-1:0]                   vco_p;

  // Control and datapath state
  state_t                       state_q, state_d;
  logic [GATE_W-1:0]            gate_len_q, gate_len_d;
  logic                         mode_q, mode_d;
  logic [GATE_W-1:0]            gate_cnt_q, gate_cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]              sat_q, sat_d;
  logic [CH_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]             out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;
  logic                         out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;
  logic [GATE_W-1:0]            gate_eff;

  // Bring clk_ref and every vco bit into the clk domain, remembering the last synced value
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_sync_q <= '0;
      ref_prev_q <= 1'b0;
      vco_sync_q <= '0;
      vco_prev_q <= '0;
    end else begin
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], clk_ref};
      ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
      for (int i = 0; i < N_CH; i++) begin
        vco_sync_q[i] <= {vco_sync_q[i][SYNC_STAGES-2:0], vco[i]};
        vco_prev_q[i] <= vco_sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  // One-cycle rising-edge pulses from the synchronised inputs
  always_comb begin
    vco_p = '0;
    ref_p = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
    for (int i = 0; i < N_CH; i++) begin
      vco_p[i] = vco_sync_q[i][SYNC_STAGES-1] & ~vco_prev_q[i];
    end
  end

  // A zero gate length means a one-period window
  assign gate_eff = (gate_len == '0) ? GATE_ONE : gate_len;

  // Next-state and datapath logic for IDLE/ARM/COUNT/DRAIN
  always_comb begin
    state_d     = state_q;
    gate_len_d  = gate_len_q;
    mode_d      = mode_q;
    gate_cnt_d  = gate_cnt_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gate_len_d = gate_eff;
          mode_d     = mode;
          state_d    = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARM: begin
        // Opening edge: edges in this same cycle are deliberately dropped
        if (ref_p) begin
          cnt_d      = '0;
          sat_d      = '0;
          gate_cnt_d = gate_len_q;
          state_d    = ST_COUNT;
        end else begin
          state_d = ST_ARM;
        end
      end

      ST_COUNT: begin
        for (int i = 0; i < N_CH; i++) begin
          if (vco_p[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
              sat_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        // Closing edge: edges in this cycle are still counted, then the counters freeze
        if (ref_p) begin
          gate_cnt_d = gate_cnt_q - GATE_ONE;
          if (gate_cnt_q == GATE_ONE) begin
            state_d     = ST_DRAIN;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = cnt_d[0];
            out_sat_d   = sat_d[0];
          end else begin
            state_d = ST_COUNT;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == LAST_CH) begin
            out_valid_d = 1'b0;
            if (mode_q && mode) begin
              gate_len_d = gate_eff;
              state_d    = ST_ARM;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d      = idx_q + CH_W'(1);
            out_data_d = cnt_q[idx_d];
            out_sat_d  = sat_q[idx_d];
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gate_len_q  <= GATE_ONE;
      mode_q      <= 1'b0;
      gate_cnt_q  <= '0;
      cnt_q       <= '0;
      sat_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_len_q  <= gate_len_d;
      mode_q      <= mode_d;
      gate_cnt_q  <= gate_cnt_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_ch    = idx_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fdc_multich.sv
// tb_fdc_multich: self-checking bench for fdc_multich.
// A 16-bit and a 4-bit counter instance share all inputs. A behavioural model
// tracks edge counts per window as unbounded integers and derives expected
// outputs each cycle; directed scenarios pin results to literal values.
module tb_fdc_multich;
  localparam int N  = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_ref = 1'b0;
  logic [3:0] vco = 4'd0;
  logic [7:0] gate_len = 8'd0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;

  logic        busy, out_sat, out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        busy_s, sat_s, valid_s;
  logic [3:0]  data_s;
  logic [1:0]  ch_s;

  fdc_multich #(.N_CH(4), .CNT_W(16), .GATE_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .clk_ref(clk_ref), .vco(vco), .gate_len(gate_len),
    .mode(mode), .start(start), .busy(busy), .out_data(out_data), .out_ch(out_ch),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready));

  fdc_multich #(.N_CH(4), .CNT_W(4), .GATE_W(8), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .reset(reset), .clk_ref(clk_ref), .vco(vco), .gate_len(gate_len),
    .mode(mode), .start(start), .busy(busy_s), .out_data(data_s), .out_ch(ch_s),
    .out_sat(sat_s), .out_valid(valid_s), .out_ready(out_ready));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus generators ----------------
  int ref_per = 0, ref_ph = 0, ref_last = 0;
  int vco_per[N], vco_ph[N], vco_last[N];
  int ready_mode = 0;
  int stall_left = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      vco_per[i] = 0; vco_ph[i] = 0; vco_last[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (ref_per != ref_last) begin
        ref_last = ref_per;
        ref_ph = (ref_per > 0) ? int'($urandom_range(0, ref_per - 1)) : 0;
      end else if (ref_per > 0) begin
        ref_ph = (ref_ph + 1) % ref_per;
      end
      clk_ref = (ref_per > 0) && (ref_ph < ref_per / 2);
      for (int i = 0; i < N; i++) begin
        if (vco_per[i] != vco_last[i]) begin
          vco_last[i] = vco_per[i];
          vco_ph[i] = (vco_per[i] > 0) ? int'($urandom_range(0, vco_per[i] - 1)) : 0;
        end else if (vco_per[i] > 0) begin
          vco_ph[i] = (vco_ph[i] + 1) % vco_per[i];
        end
        vco[i] = (vco_per[i] > 0) && (vco_ph[i] < vco_per[i] / 2);
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && out_ch == 2'd1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 waiting for opening edge, 2 counting, 3 handing out results
  int m_phase = 0, m_g = 1, m_rem = 0, m_idx = 0;
  bit m_mode = 1'b0;
  int m_cnt[N];
  bit h_ref[SS+1];
  bit h_vco[N][SS+1];

  initial begin
    bit rp;
    bit [N-1:0] vp;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk);
      // pulse seen by the core during the cycle that just ended: a 0->1 step
      // of the pin as sampled SS and SS+1 clock edges ago
      rp = h_ref[SS-1] && !h_ref[SS];
      for (int i = 0; i < N; i++) vp[i] = h_vco[i][SS-1] && !h_vco[i][SS];
      if (reset) begin
        for (int j = 0; j <= SS; j++) begin
          h_ref[j] = 1'b0;
          for (int i = 0; i < N; i++) h_vco[i][j] = 1'b0;
        end
        m_phase = 0;
        m_idx = 0;
      end else begin
        for (int j = SS; j > 0; j--) begin
          h_ref[j] = h_ref[j-1];
          for (int i = 0; i < N; i++) h_vco[i][j] = h_vco[i][j-1];
        end
        h_ref[0] = clk_ref;
        for (int i = 0; i < N; i++) h_vco[i][0] = vco[i];
        if (m_phase == 0) begin
          if (start) begin
            m_g = (gate_len == 8'd0) ? 1 : int'(gate_len);
            m_mode = mode;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (rp) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_rem = m_g;
            m_phase = 2;
          end
        end else if (m_phase == 2) begin
          for (int i = 0; i < N; i++) m_cnt[i] += int'(vp[i]);
          if (rp) begin
            m_rem--;
            if (m_rem == 0) begin
              m_phase = 3;
              m_idx = 0;
            end
          end
        end else begin
          if (out_ready) begin
            if (m_idx == N - 1) begin
              if (m_mode && mode) begin
                m_g = (gate_len == 8'd0) ? 1 : int'(gate_len);
                m_phase = 1;
              end else begin
                m_phase = 0;
              end
            end else begin
              m_idx++;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("valid", 32'(out_valid), 32'(m_phase == 3));
        check("busy_s", 32'(busy_s), 32'(m_phase != 0));
        check("valid_s", 32'(valid_s), 32'(m_phase == 3));
        if (m_phase == 3) begin
          e = m_cnt[m_idx];
          check("out_ch", 32'(out_ch), 32'(m_idx));
          check("out_data", 32'(out_data), 32'((e > 65535) ? 65535 : e));
          check("out_sat", 32'(out_sat), 32'(e > 65535));
          check("out_data_s", 32'(data_s), 32'((e > 15) ? 15 : e));
          check("out_sat_s", 32'(sat_s), 32'(e > 15));
        end
      end
    end
  end

  // ---------------- capture of accepted results ----------------
  int cap_ch[$], cap_d[$], cap_sat[$], cap_ds[$], cap_ss[$];
  int hold_cnt = 0;

  initial forever begin
    @(posedge clk);
    if (!reset && out_valid && out_ready) begin
      cap_ch.push_back(int'(out_ch));
      cap_d.push_back(int'(out_data));
      cap_sat.push_back(int'(out_sat));
      cap_ds.push_back(int'(data_s));
      cap_ss.push_back(int'(sat_s));
    end
    if (!reset && out_valid && !out_ready && out_ch == 2'd1 && out_data == 16'd16)
      hold_cnt++;
  end

  task automatic cap_clear();
    cap_ch.delete(); cap_d.delete(); cap_sat.delete(); cap_ds.delete(); cap_ss.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_data"}, 32'(out_data), 32'd0);
    check({name, "_ch"}, 32'(out_ch), 32'd0);
    check({name, "_sat"}, 32'(out_sat), 32'd0);
  endtask

  // check one group of 4 accepted results starting at base for ch0/ch1 values
  task automatic check_group(input string name, input int base, input int e0, input int e1);
    check({name, "_n"}, 32'(cap_d.size() >= base + 4), 32'd1);
    if (cap_d.size() >= base + 4) begin
      check({name, "_d0"}, 32'(cap_d[base]), 32'(e0));
      check({name, "_d1"}, 32'(cap_d[base+1]), 32'(e1));
      check({name, "_d2"}, 32'(cap_d[base+2]), 32'd0);
      check({name, "_d3"}, 32'(cap_d[base+3]), 32'd0);
      for (int k = 0; k < 4; k++) begin
        check({name, "_ch"}, 32'(cap_ch[base+k]), 32'(k));
        check({name, "_sat"}, 32'(cap_sat[base+k]), 32'd0);
      end
    end
  endtask

  task automatic set_basic(input int v0, input int v1, input logic [7:0] g, input logic md);
    ref_per = 100;
    vco_per[0] = v0; vco_per[1] = v1; vco_per[2] = 0; vco_per[3] = 0;
    gate_len = g;
    mode = md;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_sat", 32'(out_sat), 32'd0);

    // basic single shot
    set_basic(10, 25, 8'd4, 1'b0);
    ready_mode = 0;
    tick(120);
    cap_clear();
    pulse_start();
    wait_idle(3000, "s1_idle");
    check_group("s1", 0, 40, 16);
    check("s1_cap_total", 32'(cap_d.size()), 32'd4);
    check("s1_model_c0", 32'(m_cnt[0]), 32'd40);
    check("s1_model_c1", 32'(m_cnt[1]), 32'd16);

    // back-pressure at channel 1
    ready_mode = 2;
    stall_left = 5;
    hold_cnt = 0;
    cap_clear();
    pulse_start();
    wait_idle(3000, "s2_idle");
    check_group("s2", 0, 40, 16);
    check("s2_cap_total", 32'(cap_d.size()), 32'd4);
    check("s2_hold_cycles", 32'(hold_cnt), 32'd5);
    ready_mode = 0;

    // saturation on the 4-bit instance
    set_basic(4, 25, 8'd2, 1'b0);
    tick(20);
    cap_clear();
    pulse_start();
    wait_idle(3000, "s3_idle");
    check("s3_n", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() >= 2) begin
      check("s3_small_d0", 32'(cap_ds[0]), 32'd15);
      check("s3_small_sat0", 32'(cap_ss[0]), 32'd1);
      check("s3_small_d1", 32'(cap_ds[1]), 32'd8);
      check("s3_small_sat1", 32'(cap_ss[1]), 32'd0);
      check("s3_wide_d0", 32'(cap_d[0]), 32'd50);
      check("s3_wide_sat0", 32'(cap_sat[0]), 32'd0);
    end

    // gate_len of zero acts as one
    set_basic(10, 25, 8'd0, 1'b0);
    tick(20);
    cap_clear();
    pulse_start();
    wait_idle(3000, "s4_idle");
    check_group("s4", 0, 10, 4);

    // continuous mode, three windows, mode cleared during the third
    set_basic(10, 25, 8'd4, 1'b1);
    cap_clear();
    pulse_start();
    c = 0;
    while (cap_d.size() < 8 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check("s5_two_windows", 32'(cap_d.size() >= 8), 32'd1);
    tick(150);
    mode = 1'b0;
    wait_idle(3000, "s5_idle");
    check("s5_cap_total", 32'(cap_d.size()), 32'd12);
    check_group("s5_w0", 0, 40, 16);
    check_group("s5_w1", 4, 40, 16);
    check_group("s5_w2", 8, 40, 16);

    // reset in mid-COUNT, then in mid-DRAIN, then a fresh measurement
    set_basic(10, 25, 8'd4, 1'b0);
    pulse_start();
    tick(150);
    do_reset("s6_count");
    ready_mode = 3;
    pulse_start();
    c = 0;
    while (!out_valid && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("s6_reach_drain", 32'(out_valid), 32'd1);
    tick(2);
    do_reset("s6_drain");
    ready_mode = 0;
    cap_clear();
    pulse_start();
    wait_idle(3000, "s6_idle");
    check_group("s6", 0, 40, 16);

    // randomized runs against the model
    for (int r = 0; r < 6; r++) begin
      ref_per = int'($urandom_range(16, 40));
      for (int i = 0; i < N; i++)
        vco_per[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(4, 30));
      gate_len = 8'($urandom_range(0, 4));
      mode = 1'($urandom_range(0, 1));
      ready_mode = 1;
      tick(int'($urandom_range(1, 20)));
      pulse_start();
      gate_len = 8'($urandom_range(0, 4));
      tick(int'($urandom_range(10, 60)));
      pulse_start();
      if (mode) begin
        tick(int'($urandom_range(200, 600)));
        mode = 1'b0;
      end
      wait_idle(8000, "rand_idle");
    end
    ready_mode = 0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard stop if the sequence ever stalls
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
